// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage signal bundle: branch redirect, instruction-memory req/ack port and decode-side valid/ready port.
// The fetch unit connects through the master modport; memory/decode/branch models use the slave modport.
interface pc_fetch_unit_if;
  logic        i_branch_flush;
  logic [31:0] i_branch_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic        i_id_ready;
  logic        o_misalign;
  logic [31:0] o_misalign_pc;

  modport master (
    input  i_branch_flush, i_branch_pc, i_imem_ack, i_imem_rdata, i_id_ready,
    output o_imem_req, o_imem_addr, o_if_valid, o_if_instr, o_if_pc, o_misalign, o_misalign_pc
  );

  modport slave (
    output i_branch_flush, i_branch_pc, i_imem_ack, i_imem_rdata, i_id_ready,
    input  o_imem_req, o_imem_addr, o_if_valid, o_if_instr, o_if_pc, o_misalign, o_misalign_pc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC / instruction-fetch stage: one outstanding imem request, 2-entry {instr, pc} queue toward decode.
// Optional misaligned-redirect trap is compiled in when FETCH_MISALIGN_TRAP_EN is defined.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  pc_fetch_unit_if.master bus
);
  localparam int DEPTH = 2;

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_KILL, S_HALT} state_t;

  state_t                 state_reg, state_next;
  logic [31:0]            pc_reg, pc_next;
  logic [31:0]            kill_addr_reg, kill_addr_next;
  logic [1:0]             count_reg, count_next;
  logic [DEPTH-1:0][31:0] instr_reg, instr_next;
  logic [DEPTH-1:0][31:0] ipc_reg, ipc_next;

  logic        req_int;
  logic        push;
  logic        pop;
  logic [1:0]  wr_idx;
  logic [31:0] target;
  logic        redirect;

  assign req_int = (state_reg == S_REQ) || (state_reg == S_KILL);
  assign push    = (state_reg == S_REQ) && bus.i_imem_ack && !bus.i_branch_flush;
  assign pop     = (count_reg != 2'd0) && bus.i_id_ready && !bus.i_branch_flush;
  assign wr_idx  = count_reg - {1'b0, pop};

  always_comb begin
    count_next = count_reg + {1'b0, push} - {1'b0, pop};
    if (bus.i_branch_flush) begin
      count_next = 2'd0;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_reg, misalign_next;
  logic [31:0] misalign_pc_reg, misalign_pc_next;
  logic        trap_hit;

  // Once trapped, later redirects are ignored until reset.
  assign trap_hit = bus.i_branch_flush && !misalign_reg && (bus.i_branch_pc[1:0] != 2'b00);
  assign redirect = bus.i_branch_flush && !misalign_reg && !trap_hit;
  assign target   = bus.i_branch_pc;

  always_comb begin
    misalign_next    = misalign_reg;
    misalign_pc_next = misalign_pc_reg;
    if (trap_hit) begin
      misalign_next    = 1'b1;
      misalign_pc_next = bus.i_branch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_reg    <= 1'b0;
      misalign_pc_reg <= '0;
    end else begin
      misalign_reg    <= misalign_next;
      misalign_pc_reg <= misalign_pc_next;
    end
  end

  assign bus.o_misalign    = misalign_reg;
  assign bus.o_misalign_pc = misalign_pc_reg;
`else
  assign redirect          = bus.i_branch_flush;
  assign target            = bus.i_branch_pc & 32'hFFFF_FFFC;
  assign bus.o_misalign    = 1'b0;
  assign bus.o_misalign_pc = '0;
`endif

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    kill_addr_next = kill_addr_reg;
    case (state_reg)
      S_REQ: begin
        if (bus.i_branch_flush) begin
          // Request still in flight: remember its address so req/addr stay stable until ack.
          if (!bus.i_imem_ack) begin
            state_next     = S_KILL;
            kill_addr_next = pc_reg;
          end
        end else if (bus.i_imem_ack) begin
          pc_next = pc_reg + 32'd4;
          if (count_next == 2'd2) begin
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.i_branch_flush || (count_next != 2'd2)) begin
          state_next = S_REQ;
        end
      end
      S_KILL: begin
        if (bus.i_imem_ack) begin
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_HALT;
      end
    endcase
    if (redirect) begin
      pc_next = target;
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    // A pending trap turns every would-be restart into a halt, after any stale ack drains.
    if ((trap_hit || misalign_reg) && (state_next == S_REQ)) begin
      state_next = S_HALT;
    end
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] shift_instr;
      logic [31:0] shift_pc;
      if (gi < DEPTH - 1) begin : g_mid
        assign shift_instr = instr_reg[gi+1];
        assign shift_pc    = ipc_reg[gi+1];
      end else begin : g_tail
        assign shift_instr = instr_reg[gi];
        assign shift_pc    = ipc_reg[gi];
      end
      // Head is always entry 0: a pop shifts down, a push lands just above the surviving entries.
      assign instr_next[gi] = (push && (wr_idx == 2'(gi))) ? bus.i_imem_rdata :
                              (pop ? shift_instr : instr_reg[gi]);
      assign ipc_next[gi]   = (push && (wr_idx == 2'(gi))) ? pc_reg :
                              (pop ? shift_pc : ipc_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_HOLD;
      pc_reg        <= RESET_PC;
      kill_addr_reg <= '0;
      count_reg     <= '0;
      instr_reg     <= '0;
      ipc_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      kill_addr_reg <= kill_addr_next;
      count_reg     <= count_next;
      instr_reg     <= instr_next;
      ipc_reg       <= ipc_next;
    end
  end

  assign bus.o_imem_req  = req_int && !rst;
  assign bus.o_imem_addr = (state_reg == S_KILL) ? kill_addr_reg : pc_reg;
  assign bus.o_if_valid  = (count_reg != 2'd0);
  assign bus.o_if_instr  = instr_reg[0];
  assign bus.o_if_pc     = ipc_reg[0];
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: per-cycle vector table of inputs/expected outputs, plus a scoreboard
// of instructions expected at decode, filled when the bench acks a correct-path fetch.
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [31:0] bpc;
    logic        ack;
    logic        rdy;
    logic        keep;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_zero;
    logic        e_mis;
    logic [31:0] e_mpc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;
  vec_t vecs[$];
  sb_t  sb[$];

  pc_fetch_unit_if fif();

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(fif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: word content is a fixed hash of the requested address.
  assign fif.i_imem_rdata = instr_of(fif.o_imem_addr);

  task automatic add(input logic r, input logic fl, input logic [31:0] bpc, input logic ack,
                     input logic rdy, input logic keep, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc, input logic e_zero,
                     input logic e_mis, input logic [31:0] e_mpc);
    vecs.push_back('{r, fl, bpc, ack, rdy, keep, e_req, e_addr, e_valid, e_pc, e_zero, e_mis, e_mpc});
  endtask

  task automatic check32(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic check1(input string name, input int row, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    sb_t  s;
    rst                = H;
    fif.i_branch_flush = L;
    fif.i_branch_pc    = '0;
    fif.i_imem_ack     = L;
    fif.i_id_ready     = L;

    // rst flush bpc ack rdy keep | req addr valid pc zero mis mpc
    add(H, L, 0, L, H, L,  L, 32'h100, L, 0, H, L, 0);
    add(L, L, 0, L, H, L,  L, 32'h100, L, 0, H, L, 0);
    add(L, L, 0, H, H, H,  H, 32'h100, L, 0, L, L, 0);
    add(L, L, 0, H, H, H,  H, 32'h104, H, 32'h100, L, L, 0);
    add(L, L, 0, H, H, H,  H, 32'h108, H, 32'h104, L, L, 0);
    add(L, L, 0, H, L, H,  H, 32'h10C, H, 32'h108, L, L, 0);
    for (int i = 0; i < 10; i++) add(L, L, 0, L, L, L,  L, 32'h110, H, 32'h108, L, L, 0);
    add(L, L, 0, L, H, L,  L, 32'h110, H, 32'h108, L, L, 0);
    add(L, L, 0, L, H, L,  H, 32'h110, H, 32'h10C, L, L, 0);
    add(L, L, 0, H, H, H,  H, 32'h110, L, 0, L, L, 0);
    // slow ack with a redirect while waiting
    add(L, L, 0, L, H, L,  H, 32'h114, H, 32'h110, L, L, 0);
    add(L, H, 32'h200, L, H, L,  H, 32'h114, L, 0, L, L, 0);
    add(L, L, 0, L, H, L,  H, 32'h114, L, 0, L, L, 0);
    add(L, L, 0, H, H, L,  H, 32'h114, L, 0, L, L, 0);
    add(L, L, 0, H, H, L,  H, 32'h200, L, 0, L, L, 0);
    add(L, L, 0, H, L, L,  H, 32'h204, H, 32'h200, L, L, 0);
    // flush with full queue and pop, then flush with ack and pop
    add(L, H, 32'h300, L, H, L,  L, 32'h208, H, 32'h200, L, L, 0);
    add(L, L, 0, H, L, L,  H, 32'h300, L, 0, L, L, 0);
    add(L, H, 32'h400, H, H, L,  H, 32'h304, H, 32'h300, L, L, 0);
    add(L, H, 32'hFFFF_FFF8, H, H, L,  H, 32'h400, L, 0, L, L, 0);
    // address wrap
    add(L, L, 0, H, H, H,  H, 32'hFFFF_FFF8, L, 0, L, L, 0);
    add(L, L, 0, H, H, H,  H, 32'hFFFF_FFFC, H, 32'hFFFF_FFF8, L, L, 0);
    add(L, L, 0, H, H, H,  H, 32'h0, H, 32'hFFFF_FFFC, L, L, 0);
    add(L, L, 0, L, H, L,  H, 32'h4, H, 32'h0, L, L, 0);
    // misaligned redirect while a request is outstanding
    add(L, H, 32'h202, L, H, L,  H, 32'h4, L, 0, L, L, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    add(L, L, 0, H, H, L,  H, 32'h4, L, 0, L, H, 32'h202);
    add(L, L, 0, L, H, L,  L, 32'h4, L, 0, L, H, 32'h202);
    add(L, H, 32'h500, L, H, L,  L, 32'h4, L, 0, L, H, 32'h202);
    add(H, L, 0, L, H, L,  L, 32'h4, L, 0, L, H, 32'h202);
`else
    add(L, L, 0, H, H, L,  H, 32'h4, L, 0, L, L, 0);
    add(L, L, 0, H, H, H,  H, 32'h200, L, 0, L, L, 0);
    add(L, L, 0, L, H, L,  H, 32'h204, H, 32'h200, L, L, 0);
    add(H, L, 0, L, H, L,  H, 32'h204, L, 0, L, L, 0);
`endif
    // restart after a mid-request reset
    add(L, L, 0, L, H, L,  L, 32'h100, L, 0, H, L, 0);
    add(L, L, 0, H, H, H,  H, 32'h100, L, 0, L, L, 0);
    add(L, L, 0, L, H, L,  H, 32'h104, H, 32'h100, L, L, 0);

    repeat (2) @(posedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      @(posedge clk);
      #1;
      check1("req", k, fif.o_imem_req, v.e_req);
      check32("addr", k, fif.o_imem_addr, v.e_addr);
      check1("valid", k, fif.o_if_valid, v.e_valid);
      if (v.e_valid || v.e_zero) check32("if_pc", k, fif.o_if_pc, v.e_pc);
      if (v.e_zero) check32("if_instr", k, fif.o_if_instr, 32'h0);
      check1("misalign", k, fif.o_misalign, v.e_mis);
      check32("misalign_pc", k, fif.o_misalign_pc, v.e_mpc);

      rst                = v.rst;
      fif.i_branch_flush = v.flush;
      fif.i_branch_pc    = v.bpc;
      fif.i_imem_ack     = v.ack;
      fif.i_id_ready     = v.rdy;
      if (v.keep) sb.push_back('{pc: v.e_addr, instr: instr_of(v.e_addr)});
      #1;
      if (v.rst) check1("req_drop", k, fif.o_imem_req, L);
      if (fif.o_if_valid && fif.i_id_ready && !fif.i_branch_flush) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb_extra row %0d: got pc %h expected no instruction", k, fif.o_if_pc);
        end else begin
          s = sb.pop_front();
          $display("row %0d deliver pc=%h instr=%h", k, fif.o_if_pc, fif.o_if_instr);
          check32("sb_pc", k, fif.o_if_pc, s.pc);
          check32("sb_instr", k, fif.o_if_instr, s.instr);
        end
      end
    end
    check32("sb_drain", vecs.size(), 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
